cache_req_index_arbiter: RTL and testbench
==========================================

# cache_req_index_arbiter

Parametrised successor of the single-request index extractor at the DRAM-cache front end. Accepts AXI-style read (AR) and write (AW) address requests on independent channels, buffers one request per channel, arbitrates between them (round-robin or read-priority), and pushes one packed request per cycle into the downstream request FIFO. It extracts and exports the cache set index, honours FIFO almost-full back-pressure, and keeps saturating per-direction push counters.

## Interface
- ID_W, 32: AXI ID width.
- ADDR_W, 32: address width.
- OFFSET_W, 6: line-offset bits skipped below the index.
- INDEX_W, 4: set-index bits; OFFSET_W+INDEX_W < ADDR_W required.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed read priority.
- CNT_W, 16: push-counter width.
- DATA_W, 1+ID_W+ADDR_W: derived FIFO word width; not overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arid_i  in  ID_W  read request ID.
- araddr_i  in  ADDR_W  read address.
- arvalid_i  in  1  read request valid.
- arready_o  out  1  read holding register empty.
- awid_i  in  ID_W  write request ID.
- awaddr_i  in  ADDR_W  write address.
- awvalid_i  in  1  write request valid.
- awready_o  out  1  write holding register empty.
- index_o  out  INDEX_W  set index of the last pushed request.
- fifo_afull_i  in  1  downstream FIFO almost full.
- fifo_write_en_o  out  1  one-cycle push strobe.
- fifo_data_o  out  DATA_W  {is_write, id, addr}, is_write at MSB.
- rd_cnt_o  out  CNT_W  saturating count of pushed reads.
- wr_cnt_o  out  CNT_W  saturating count of pushed writes.

## Operation
- Each channel has one holding register (valid, id, addr).
- arready_o = !ar_hold_valid and awready_o = !aw_hold_valid, combinational from registered state.
- A handshake (valid && ready at a rising edge) loads the holding register.
- A holding register cannot be reloaded in the same cycle it is granted. Per-channel throughput is therefore 1 request per 2 cycles; with both channels busy, aggregate throughput is 1 per cycle.
- Grant is evaluated combinationally each cycle. It occurs only when fifo_afull_i = 0 and at least one holding register is valid.
  - One requester valid: it wins.
  - Both valid, ARB_MODE = 0: the winner is the channel the RR pointer favours. After each grant, the pointer flips to favour the other channel.
  - Both valid, ARB_MODE = 1: AR always wins.
- On grant, at the next edge:
  - fifo_write_en_o = 1.
  - fifo_data_o = {is_write, id, addr}.
  - index_o = addr[OFFSET_W +: INDEX_W].
  - The winner's holding register is cleared.
  - The matching counter increments; it saturates at 2^CNT_W−1 (no wrap).
- With no grant: fifo_write_en_o = 0. fifo_data_o and index_o hold their last values.
- fifo_afull_i = 1 blocks all grants. Holding registers stay full, ready stays low, and the upstream is back-pressured.
- The downstream FIFO must assert afull with at least 1 free slot remaining, because one push may already be registered.

## Timing
- Reset (rst = 1 at an edge) clears:
  - both holding registers;
  - fifo_write_en_o, fifo_data_o, index_o, rd_cnt_o, wr_cnt_o, all to 0.
- The RR pointer resets to favour AR.
- arready_o and awready_o read 0 while rst is high and 1 in the first cycle after reset.
- Reset mid-operation discards buffered requests with no push.
- Latency: handshake at edge k, grant in cycle k..k+1, fifo_write_en_o high for cycle k+1..k+2. That is 1 cycle from holding-register load to strobe, if not blocked.
- fifo_afull_i is sampled in the grant cycle only; deassertion allows a grant in that same cycle.
- Simultaneous AR and AW handshakes at one edge: both load, then arbitration is as above on consecutive cycles.
- fifo_write_en_o never stays high for 2 cycles for the same request.

## Test plan
- Reset, then single read: ARB_MODE=0, araddr_i=0x0000_01C0, arid_i=3, one handshake.
  - Required: fifo_write_en_o pulses 1 cycle later.
  - Required: fifo_data_o={0,3,0x1C0}, index_o=7, rd_cnt_o=1.
- Simultaneous AR(addr 0x40, id 1) and AW(addr 0x80, id 2) on the same edge, ARB_MODE=0.
  - Required: pushes on consecutive cycles, AR first then AW.
  - Required: index_o 1 then 2; wr_cnt_o=1.
- Continuous valid on both channels for 20 cycles, ARB_MODE=0.
  - Required: pushes strictly alternate AR/AW at 1 per cycle once the pipeline fills.
  - Required: rd_cnt_o and wr_cnt_o differ by ≤1.
- Same stimulus with ARB_MODE=1.
  - Required: AR wins whenever both holding registers are valid.
  - Required: AW is pushed only in cycles when the AR holding register is empty.
- fifo_afull_i=1 for 10 cycles with both channels loaded.
  - Required: no fifo_write_en_o pulse; arready_o=awready_o=0.
  - Required: after release, both requests are pushed within 2 cycles, none lost or duplicated.
- CNT_W=4, 20 reads, then rst mid-request.
  - Required: rd_cnt_o saturates at 15.
  - Required: after reset, the buffered request is dropped and all outputs are 0.

Source files
------------

// File: rtl/cache_req_index_arbiter.sv
// AR/AW request arbiter for the DRAM-cache front end: one holding register per
// channel, round-robin or read-priority grant, packed push into the request FIFO.
module cache_req_index_arbiter #(
    parameter int unsigned ID_W     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DATA_W   = 1 + ID_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    input  logic [ID_W-1:0]   awid_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    output logic [INDEX_W-1:0] index_o,
    input  logic              fifo_afull_i,
    output logic              fifo_write_en_o,
    output logic [DATA_W-1:0] fifo_data_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    typedef enum logic {
        FAV_AR = 1'b0,
        FAV_AW = 1'b1
    } rr_e;

    rr_e               rr_q, rr_d;

    logic              ar_v_q, ar_v_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;

    logic              aw_v_q, aw_v_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;

    logic              we_q, we_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic              ar_hs, aw_hs;
    logic              gnt_ar, gnt_aw;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;

    // Ready is forced low during reset so nothing is accepted on the reset edge.
    assign arready_o = !ar_v_q && !rst;
    assign awready_o = !aw_v_q && !rst;
    assign ar_hs     = arvalid_i && arready_o;
    assign aw_hs     = awvalid_i && awready_o;

    always_comb begin
        gnt_ar = 1'b0;
        gnt_aw = 1'b0;
        if (!fifo_afull_i) begin
            if (ar_v_q && aw_v_q) begin
                if (ARB_MODE == 1 || rr_q == FAV_AR) begin
                    gnt_ar = 1'b1;
                end else begin
                    gnt_aw = 1'b1;
                end
            end else begin
                gnt_ar = ar_v_q;
                gnt_aw = aw_v_q;
            end
        end
    end

    assign sel_id   = gnt_aw ? aw_id_q   : ar_id_q;
    assign sel_addr = gnt_aw ? aw_addr_q : ar_addr_q;

    always_comb begin
        rr_d      = rr_q;
        ar_v_d    = ar_v_q;
        ar_id_d   = ar_id_q;
        ar_addr_d = ar_addr_q;
        aw_v_d    = aw_v_q;
        aw_id_d   = aw_id_q;
        aw_addr_d = aw_addr_q;
        we_d      = 1'b0;
        data_d    = data_q;
        index_d   = index_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;

        // A granted register is full, so its ready is low and no reload can collide.
        if (gnt_ar) begin
            ar_v_d = 1'b0;
        end
        if (ar_hs) begin
            ar_v_d    = 1'b1;
            ar_id_d   = arid_i;
            ar_addr_d = araddr_i;
        end
        if (gnt_aw) begin
            aw_v_d = 1'b0;
        end
        if (aw_hs) begin
            aw_v_d    = 1'b1;
            aw_id_d   = awid_i;
            aw_addr_d = awaddr_i;
        end

        if (gnt_ar || gnt_aw) begin
            we_d    = 1'b1;
            data_d  = {gnt_aw, sel_id, sel_addr};
            index_d = sel_addr[OFFSET_W +: INDEX_W];
            rr_d    = gnt_ar ? FAV_AW : FAV_AR;
        end

        if (gnt_ar && rd_cnt_q != '1) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (gnt_aw && wr_cnt_q != '1) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= FAV_AR;
            ar_v_q    <= 1'b0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            aw_v_q    <= 1'b0;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            rr_q      <= rr_d;
            ar_v_q    <= ar_v_d;
            ar_id_q   <= ar_id_d;
            ar_addr_q <= ar_addr_d;
            aw_v_q    <= aw_v_d;
            aw_id_q   <= aw_id_d;
            aw_addr_q <= aw_addr_d;
            we_q      <= we_d;
            data_q    <= data_d;
            index_q   <= index_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign fifo_write_en_o = we_q;
    assign fifo_data_o     = data_q;
    assign index_o         = index_q;
    assign rd_cnt_o        = rd_cnt_q;
    assign wr_cnt_o        = wr_cnt_q;

endmodule

// File: tb/tb_cache_req_index_arbiter.sv
// Bench: three instances (round-robin, read-priority, 4-bit counters) on shared
// stimulus; expected pushes are queued at handshake time and popped on each strobe.
module tb_cache_req_index_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] arid, araddr, awid, awaddr;
    logic        arvalid, awvalid, afull;

    logic        arready0, awready0, we0;
    logic        arready1, awready1, we1;
    logic        arready2, awready2, we2;
    logic [64:0] data0, data1, data2;
    logic [3:0]  idx0, idx1, idx2;
    logic [15:0] rc0, wc0, rc1, wc1;
    logic [3:0]  rc2, wc2;

    int n_vec = 0;
    int n_err = 0;

    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic [64:0] q2[$];

    bit hs_ar, hs_aw;
    bit rr_swap = 0;
    bit no_enq  = 0;
    bit samp_we0, samp_we1;
    int ar_tot, aw_tot;
    logic prev_arready1;

    cache_req_index_arbiter #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready0),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready0),
        .index_o(idx0), .fifo_afull_i(afull), .fifo_write_en_o(we0), .fifo_data_o(data0),
        .rd_cnt_o(rc0), .wr_cnt_o(wc0));

    cache_req_index_arbiter #(.ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready1),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready1),
        .index_o(idx1), .fifo_afull_i(afull), .fifo_write_en_o(we1), .fifo_data_o(data1),
        .rd_cnt_o(rc1), .wr_cnt_o(wc1));

    cache_req_index_arbiter #(.ARB_MODE(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready2),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready2),
        .index_o(idx2), .fifo_afull_i(afull), .fifo_write_en_o(we2), .fifo_data_o(data2),
        .rd_cnt_o(rc2), .wr_cnt_o(wc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitors: every strobe must match the oldest expected push.
    always @(negedge clk) begin
        logic [64:0] e;
        if (we0) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL push_dut0 unexpected push data=%h", data0);
            end else begin
                e = q0.pop_front();
                if (data0 !== e || idx0 !== e[9:6]) begin
                    n_err++;
                    $display("FAIL push_dut0 got data=%h idx=%0d want data=%h idx=%0d", data0, idx0, e, e[9:6]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (we1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL push_dut1 unexpected push data=%h", data1);
            end else begin
                e = q1.pop_front();
                if (data1 !== e || idx1 !== e[9:6]) begin
                    n_err++;
                    $display("FAIL push_dut1 got data=%h idx=%0d want data=%h idx=%0d", data1, idx1, e, e[9:6]);
                end
            end
            if (data1[64] === 1'b1) begin
                n_vec++;
                if (prev_arready1 !== 1'b1) begin
                    n_err++;
                    $display("FAIL prio_aw_while_ar_full got arready=%b want 1", prev_arready1);
                end
            end
        end
        prev_arready1 = arready1;
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (we2) begin
            n_vec++;
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL push_dut2 unexpected push data=%h", data2);
            end else begin
                e = q2.pop_front();
                if (data2 !== e || idx2 !== e[9:6]) begin
                    n_err++;
                    $display("FAIL push_dut2 got data=%h idx=%0d want data=%h idx=%0d", data2, idx2, e, e[9:6]);
                end
            end
        end
    end

    // One clock: sample handshakes mid-cycle, enqueue expected pushes at the edge.
    task automatic cyc();
        logic [64:0] ar_item, aw_item;
        @(negedge clk);
        hs_ar    = arvalid && arready0;
        hs_aw    = awvalid && awready0;
        samp_we0 = we0;
        samp_we1 = we1;
        ar_item  = {1'b0, arid, araddr};
        aw_item  = {1'b1, awid, awaddr};
        @(posedge clk);
        if (!no_enq) begin
            if (hs_ar && hs_aw && rr_swap) begin
                q0.push_back(aw_item); q0.push_back(ar_item);
                q2.push_back(aw_item); q2.push_back(ar_item);
                q1.push_back(ar_item); q1.push_back(aw_item);
            end else begin
                if (hs_ar) begin
                    q0.push_back(ar_item); q1.push_back(ar_item); q2.push_back(ar_item);
                end
                if (hs_aw) begin
                    q0.push_back(aw_item); q1.push_back(aw_item); q2.push_back(aw_item);
                end
            end
            if (hs_ar) ar_tot++;
            if (hs_aw) aw_tot++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q2.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        int exp_rd2, exp_wr2;
        exp_rd2 = (ar_tot > 15) ? 15 : ar_tot;
        exp_wr2 = (aw_tot > 15) ? 15 : aw_tot;
        n_vec++;
        if (int'(rc0) != ar_tot || int'(wc0) != aw_tot || int'(rc1) != ar_tot || int'(wc1) != aw_tot) begin
            n_err++;
            $display("FAIL counts got rd=%0d/%0d wr=%0d/%0d want rd=%0d wr=%0d", rc0, rc1, wc0, wc1, ar_tot, aw_tot);
        end
        n_vec++;
        if (int'(rc2) != exp_rd2 || int'(wc2) != exp_wr2) begin
            n_err++;
            $display("FAIL counts_sat got rd=%0d wr=%0d want rd=%0d wr=%0d", rc2, wc2, exp_rd2, exp_wr2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; afull = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({arready0, awready0, arready1, awready1, arready2, awready2} !== 6'b0) begin
            n_err++;
            $display("FAIL ready_in_reset got %b want 000000",
                     {arready0, awready0, arready1, awready1, arready2, awready2});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        ar_tot = 0; aw_tot = 0;
        @(negedge clk);
        n_vec++;
        if ({arready0, awready0, arready1, awready1, arready2, awready2} !== 6'b111111) begin
            n_err++;
            $display("FAIL ready_after_reset got %b want 111111",
                     {arready0, awready0, arready1, awready1, arready2, awready2});
        end
        n_vec++;
        if ({we0, we1, we2} !== 3'b0 || data0 !== '0 || data1 !== '0 || data2 !== '0 ||
            idx0 !== '0 || idx1 !== '0 || idx2 !== '0) begin
            n_err++;
            $display("FAIL outputs_after_reset got we=%b d0=%h idx0=%0d want all 0", {we0, we1, we2}, data0, idx0);
        end
        n_vec++;
        if (rc0 !== '0 || wc0 !== '0 || rc1 !== '0 || wc1 !== '0 || rc2 !== '0 || wc2 !== '0) begin
            n_err++;
            $display("FAIL counts_after_reset got rd=%0d/%0d/%0d wr=%0d/%0d/%0d want 0", rc0, rc1, rc2, wc0, wc1, wc2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        logic [64:0] want;
        want = {1'b0, 32'd3, 32'h0000_01C0};
        arid = 32'd3; araddr = 32'h0000_01C0; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (we0 !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency got we=%b want 0 in load cycle", we0);
        end
        @(negedge clk);
        n_vec++;
        if (we0 !== 1'b1 || data0 !== want || idx0 !== 4'd7 || rc0 !== 16'd1) begin
            n_err++;
            $display("FAIL single_read got we=%b data=%h idx=%0d rd=%0d want 1 %h 7 1", we0, data0, idx0, rc0, want);
        end
        @(negedge clk);
        n_vec++;
        if (we0 !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse got we=%b want 0", we0);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_simultaneous();
        arid = 32'd1; araddr = 32'h40; awid = 32'd2; awaddr = 32'h80;
        arvalid = 1'b1; awvalid = 1'b1;
        cyc();
        arvalid = 1'b0; awvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (we0 !== 1'b1 || data0[64] !== 1'b0 || idx0 !== 4'd1) begin
            n_err++;
            $display("FAIL simul_first got we=%b wr=%b idx=%0d want 1 0 1", we0, data0[64], idx0);
        end
        @(negedge clk);
        n_vec++;
        if (we0 !== 1'b1 || data0[64] !== 1'b1 || idx0 !== 4'd2 || wc0 !== 16'd1) begin
            n_err++;
            $display("FAIL simul_second got we=%b wr=%b idx=%0d wcnt=%0d want 1 1 2 1", we0, data0[64], idx0, wc0);
        end
        @(posedge clk);
        #1;
        drain();
        check_counts();
    endtask

    task automatic test_continuous();
        int strobes0, strobes1, diff;
        strobes0 = 0; strobes1 = 0;
        arid = 32'd16; araddr = 32'h0000_1000;
        awid = 32'd48; awaddr = 32'h2000_0000;
        arvalid = 1'b1; awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i >= 2) begin
                strobes0 += int'(samp_we0);
                strobes1 += int'(samp_we1);
            end
            if (hs_ar) begin arid = arid + 1; araddr = araddr + 32'h40; end
            if (hs_aw) begin awid = awid + 1; awaddr = awaddr + 32'h1C0; end
        end
        arvalid = 1'b0; awvalid = 1'b0;
        n_vec++;
        if (strobes0 != 18 || strobes1 != 18) begin
            n_err++;
            $display("FAIL throughput got %0d/%0d strobes want 18/18", strobes0, strobes1);
        end
        drain();
        check_counts();
        diff = int'(rc0) - int'(wc0);
        n_vec++;
        if (diff > 1 || diff < -1) begin
            n_err++;
            $display("FAIL rr_balance got rd=%0d wr=%0d want |diff|<=1", rc0, wc0);
        end
    endtask

    task automatic test_rr_vs_priority();
        arid = 32'd5; araddr = 32'h2C0; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        drain();
        rr_swap = 1'b1;
        arid = 32'd6; araddr = 32'h300; awid = 32'd7; awaddr = 32'h340;
        arvalid = 1'b1; awvalid = 1'b1;
        cyc();
        arvalid = 1'b0; awvalid = 1'b0; rr_swap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (we0 !== 1'b1 || data0[64] !== 1'b1 || we1 !== 1'b1 || data1[64] !== 1'b0) begin
            n_err++;
            $display("FAIL rr_vs_prio got rr_wr=%b prio_wr=%b want 1 0", data0[64], data1[64]);
        end
        @(posedge clk);
        #1;
        drain();
        check_counts();
    endtask

    task automatic test_afull();
        int pushes;
        pushes = 0;
        afull = 1'b1;
        arid = 32'd9; araddr = 32'h5C0; awid = 32'd10; awaddr = 32'h600;
        arvalid = 1'b1; awvalid = 1'b1;
        cyc();
        arvalid = 1'b0; awvalid = 1'b0;
        n_vec++;
        if (!(hs_ar && hs_aw)) begin
            n_err++;
            $display("FAIL afull_load got hs=%b%b want 11", hs_ar, hs_aw);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if ({we0, we1, we2} !== 3'b0 || {arready0, awready0, arready1, awready1} !== 4'b0) begin
                n_err++;
                $display("FAIL afull_block got we=%b ready=%b want 000 0000", {we0, we1, we2},
                         {arready0, awready0, arready1, awready1});
            end
        end
        @(posedge clk);
        #1;
        afull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pushes += int'(we0);
        end
        n_vec++;
        if (pushes != 2) begin
            n_err++;
            $display("FAIL afull_release got %0d pushes want 2", pushes);
        end
        @(posedge clk);
        #1;
        drain();
        check_counts();
    endtask

    task automatic test_saturate_and_reset();
        int budget;
        int strobes;
        budget = 0;
        strobes = 0;
        arid = 32'd100; araddr = 32'h0;
        arvalid = 1'b1;
        while (ar_tot < 20 && budget < 100) begin
            cyc();
            budget++;
            if (hs_ar) begin arid = arid + 1; araddr = araddr + 32'h40; end
        end
        arvalid = 1'b0;
        n_vec++;
        if (ar_tot != 20) begin
            n_err++;
            $display("FAIL sat_handshakes got %0d want 20", ar_tot);
        end
        drain();
        n_vec++;
        if (rc2 !== 4'd15 || rc0 !== 16'd20) begin
            n_err++;
            $display("FAIL saturate got rd4=%0d rd16=%0d want 15 20", rc2, rc0);
        end
        afull = 1'b1;
        no_enq = 1'b1;
        arid = 32'hDEAD; araddr = 32'hBEC0; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        no_enq = 1'b0;
        n_vec++;
        if (!hs_ar) begin
            n_err++;
            $display("FAIL midreq_load got hs=%b want 1", hs_ar);
        end
        test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            strobes += int'(we0) + int'(we1) + int'(we2);
        end
        n_vec++;
        if (strobes != 0) begin
            n_err++;
            $display("FAIL midreq_dropped got %0d strobes want 0", strobes);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; afull = 1'b0;
        arvalid = 1'b0; awvalid = 1'b0;
        arid = '0; araddr = '0; awid = '0; awaddr = '0;
        prev_arready1 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_reset();
        test_simultaneous();
        test_reset();
        test_continuous();
        test_reset();
        test_rr_vs_priority();
        test_reset();
        test_afull();
        test_reset();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
